// File: rtl/flow_controller.sv
// flow_controller: call/ret/jmp/halt front end for program_sequencer; optional IRQ entry under FLOW_IRQ_EN
module flow_controller #(
    parameter int                  ADDR_W      = 8,
    parameter int                  STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0]   IRQ_VECTOR  = 8'hF0
) (
    input  logic                               clk,
    input  logic                               sync_reset,
    input  logic [ADDR_W-1:0]                  pm_addr,
    input  logic                               op_jmp,
    input  logic                               op_jmp_nz,
    input  logic                               op_call,
    input  logic                               op_ret,
    input  logic                               op_halt,
    input  logic [ADDR_W-1:0]                  target,
    input  logic                               zero_flag,
    input  logic                               resume,
    input  logic                               irq,
    output logic                               seq_jmp,
    output logic                               seq_jmp_nz,
    output logic                               seq_dont_jmp,
    output logic [ADDR_W-1:0]                  seq_jmp_addr,
    output logic                               halted,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
    output logic                               stack_ovf,
    output logic                               stack_unf
);
    localparam int DW = $clog2(STACK_DEPTH + 1);
    localparam int AW = $clog2(STACK_DEPTH);
    localparam logic [DW-1:0] FULL = DW'(STACK_DEPTH);

    typedef enum logic {RUN, HALT} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   stack [STACK_DEPTH];
    logic [ADDR_W-1:0]   ret_addr, push_data, top;
    logic [DW-1:0]       top_idx;
    logic                full, empty, push, pop, set_ovf, set_unf, irq_ok;

    assign ret_addr = pm_addr + ADDR_W'(1);
    assign full     = depth == FULL;
    assign empty    = depth == '0;
    assign top_idx  = depth - DW'(1);
    assign top      = stack[top_idx[AW-1:0]];
    assign halted   = state == HALT;

`ifdef FLOW_IRQ_EN
    logic          in_isr;
    logic [DW-1:0] isr_base;
    assign irq_ok = irq && !in_isr && !full;
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            in_isr   <= 1'b0;
            isr_base <= '0;
        end else if (irq_ok) begin
            in_isr   <= 1'b1;
            isr_base <= depth;
        end else if (pop && in_isr && top_idx == isr_base) begin
            in_isr   <= 1'b0;
        end
    end
`else
    logic unused_irq;
    assign unused_irq = ^{irq, IRQ_VECTOR};
    assign irq_ok     = 1'b0;
`endif

    // One action per cycle; the if-chain order is the priority order
    always_comb begin
        seq_jmp      = 1'b0;
        seq_jmp_nz   = 1'b0;
        seq_dont_jmp = 1'b0;
        seq_jmp_addr = '0;
        state_nxt    = state;
        push         = 1'b0;
        pop          = 1'b0;
        push_data    = ret_addr;
        set_ovf      = 1'b0;
        set_unf      = 1'b0;
        if (irq_ok) begin
            seq_jmp      = 1'b1;
            seq_jmp_addr = IRQ_VECTOR;
            push         = 1'b1;
            push_data    = state == RUN ? pm_addr : ret_addr;
            state_nxt    = RUN;
        end else if (state == HALT) begin
            seq_jmp      = !resume;
            seq_jmp_addr = resume ? '0 : pm_addr;
            state_nxt    = resume ? RUN : HALT;
        end else if (op_ret) begin
            seq_jmp      = !empty;
            seq_jmp_addr = empty ? '0 : top;
            pop          = !empty;
            set_unf      = empty;
        end else if (op_call) begin
            seq_jmp      = !full;
            seq_jmp_addr = full ? '0 : target;
            push         = !full;
            set_ovf      = full;
        end else if (op_jmp) begin
            seq_jmp      = 1'b1;
            seq_jmp_addr = target;
        end else if (op_jmp_nz) begin
            seq_jmp_nz   = 1'b1;
            seq_dont_jmp = zero_flag;
            seq_jmp_addr = target;
        end else if (op_halt) begin
            seq_jmp      = 1'b1;
            seq_jmp_addr = pm_addr;
            state_nxt    = HALT;
        end
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state     <= RUN;
            depth     <= '0;
            stack_ovf <= 1'b0;
            stack_unf <= 1'b0;
        end else begin
            state     <= state_nxt;
            depth     <= depth + DW'(push) - DW'(pop);
            stack_ovf <= stack_ovf | set_ovf;
            stack_unf <= stack_unf | set_unf;
        end
    end

    always_ff @(posedge clk) begin
        if (push) stack[depth[AW-1:0]] <= push_data;
    end
endmodule

// File: tb/tb_flow_controller.sv
// tb_flow_controller: directed checks of flow_controller driving a behavioural sequencer
module tb_flow_controller;
    logic       clk = 1'b0;
    logic       sync_reset = 1'b0;
    logic [7:0] pm_addr = '0, target = '0, seq_jmp_addr;
    logic       op_jmp = 0, op_jmp_nz = 0, op_call = 0, op_ret = 0, op_halt = 0;
    logic       zero_flag = 0, resume = 0, irq = 0;
    logic       seq_jmp, seq_jmp_nz, seq_dont_jmp, halted, stack_ovf, stack_unf;
    logic [2:0] depth;
    int         errors = 0, checks = 0;

    always #5 clk = ~clk;

    flow_controller dut (
        .clk(clk), .sync_reset(sync_reset), .pm_addr(pm_addr),
        .op_jmp(op_jmp), .op_jmp_nz(op_jmp_nz), .op_call(op_call), .op_ret(op_ret), .op_halt(op_halt),
        .target(target), .zero_flag(zero_flag), .resume(resume), .irq(irq),
        .seq_jmp(seq_jmp), .seq_jmp_nz(seq_jmp_nz), .seq_dont_jmp(seq_dont_jmp), .seq_jmp_addr(seq_jmp_addr),
        .halted(halted), .depth(depth), .stack_ovf(stack_ovf), .stack_unf(stack_unf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        logic [7:0] nxt;
        nxt = seq_jmp ? seq_jmp_addr : (seq_jmp_nz && !seq_dont_jmp) ? seq_jmp_addr : pm_addr + 8'd1;
        @(posedge clk);
        #1;
        pm_addr = nxt;
    endtask

    task automatic clear_ops();
        op_jmp = 0; op_jmp_nz = 0; op_call = 0; op_ret = 0; op_halt = 0; resume = 0; zero_flag = 0;
    endtask

    task automatic do_reset();
        sync_reset = 1;
        step();
        step();
        sync_reset = 0;
        #1;
    endtask

    initial begin
        do_reset();
        pm_addr = 8'h00;
        #1;
        check("rst_depth", depth, 0);
        check("rst_halted", halted, 0);
        check("rst_ovf", stack_ovf, 0);
        check("rst_unf", stack_unf, 0);
        check("idle_seq", {seq_jmp, seq_jmp_nz, seq_dont_jmp, seq_jmp_addr}, 0);

        pm_addr = 8'h10; target = 8'h40; op_call = 1; #1;
        check("call_jmp", seq_jmp, 1);
        check("call_addr", seq_jmp_addr, 8'h40);
        step(); clear_ops(); #1;
        check("call_depth", depth, 1);
        op_ret = 1; #1;
        check("ret_jmp", seq_jmp, 1);
        check("ret_addr", seq_jmp_addr, 8'h11);
        step(); clear_ops(); #1;
        check("ret_depth", depth, 0);

        pm_addr = 8'hFF; target = 8'h20; op_call = 1; #1;
        step(); clear_ops(); #1;
        check("wrap_depth", depth, 1);
        op_ret = 1; #1;
        check("wrap_ret_addr", seq_jmp_addr, 8'h00);
        step(); #1;
        check("unf_nojmp", seq_jmp, 0);
        step(); clear_ops(); #1;
        check("unf_set", stack_unf, 1);
        check("unf_depth", depth, 0);
        step(); #1;
        check("unf_sticky", stack_unf, 1);

        for (int i = 0; i < 5; i++) begin
            pm_addr = 8'h60 + 8'(i); target = 8'h70 + 8'(i); op_call = 1; #1;
            if (i == 4) check("ovf_nojmp", seq_jmp, 0);
            else check("nest_addr", seq_jmp_addr, 32'(8'h70 + 8'(i)));
            step(); clear_ops(); #1;
        end
        check("ovf_depth", depth, 4);
        check("ovf_set", stack_ovf, 1);
        for (int i = 3; i >= 0; i--) begin
            op_ret = 1; #1;
            check("lifo_addr", seq_jmp_addr, 32'(8'h61 + 8'(i)));
            step(); clear_ops(); #1;
            check("lifo_depth", depth, 32'(i));
        end
        check("ovf_sticky", stack_ovf, 1);

        do_reset();
        check("rst2_ovf", stack_ovf, 0);
        check("rst2_unf", stack_unf, 0);

        pm_addr = 8'h30; op_halt = 1; #1;
        check("halt_jmp", {seq_jmp, seq_jmp_addr}, {1'b1, 8'h30});
        step(); clear_ops(); #1;
        check("halted", halted, 1);
        op_jmp = 1; target = 8'h99;
        for (int i = 0; i < 10; i++) begin
            step(); #1;
            check("halt_hold", pm_addr, 8'h30);
        end
        check("halt_still", halted, 1);
        op_jmp = 0; resume = 1; #1;
        check("resume_seq", seq_jmp, 0);
        step(); clear_ops(); #1;
        check("resume_pc", pm_addr, 8'h31);
        check("resume_halted", halted, 0);

        pm_addr = 8'h50; target = 8'h55; op_jmp_nz = 1; zero_flag = 0; #1;
        check("jnz_nz0", {seq_jmp, seq_jmp_nz, seq_dont_jmp, seq_jmp_addr}, {3'b010, 8'h55});
        zero_flag = 1; #1;
        check("jnz_z1", {seq_jmp, seq_jmp_nz, seq_dont_jmp, seq_jmp_addr}, {3'b011, 8'h55});
        clear_ops();
        pm_addr = 8'h12; target = 8'h77; op_jmp = 1; op_call = 1; #1;
        check("prio_addr", {seq_jmp, seq_jmp_addr}, {1'b1, 8'h77});
        step(); clear_ops(); #1;
        check("prio_push", depth, 1);
        op_ret = 1; #1;
        check("prio_ret", seq_jmp_addr, 8'h13);
        step(); clear_ops(); #1;

`ifdef FLOW_IRQ_EN
        do_reset();
        pm_addr = 8'h22; target = 8'h33; op_jmp = 1; irq = 1; #1;
        check("irq_addr", {seq_jmp, seq_jmp_addr}, {1'b1, 8'hF0});
        step(); clear_ops(); #1;
        check("irq_pc", pm_addr, 8'hF0);
        check("irq_depth", depth, 1);
        check("irq_masked", seq_jmp, 0);
        target = 8'hA0; op_call = 1; #1;
        check("isr_call", seq_jmp_addr, 8'hA0);
        step(); clear_ops(); #1;
        check("isr_depth2", depth, 2);
        op_ret = 1; #1;
        check("isr_ret1", seq_jmp_addr, 8'hF1);
        step(); clear_ops(); #1;
        check("isr_still_masked", seq_jmp, 0);
        op_ret = 1; #1;
        check("isr_ret_final", seq_jmp_addr, 8'h22);
        step(); clear_ops(); #1;
        check("isr_exit_depth", depth, 0);
        check("irq_retaken", {seq_jmp, seq_jmp_addr}, {1'b1, 8'hF0});
        step(); irq = 0;
        do_reset();
        check("isr_rst_depth", depth, 0);
        irq = 1; #1;
        check("isr_rst_unmasked", {seq_jmp, seq_jmp_addr}, {1'b1, 8'hF0});
        irq = 0;
`else
        pm_addr = 8'h22; target = 8'h33; op_jmp = 1; irq = 1; #1;
        check("irq_ignored", {seq_jmp, seq_jmp_addr}, {1'b1, 8'h33});
        step(); clear_ops(); #1;
        check("irq_nopush", depth, 0);
        check("irq_idle", seq_jmp, 0);
        irq = 0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
